prio_enc_rr: RTL and testbench

//  Parametrised, registered successor to the 8:3 priority encoder. Latches N request lines into a

---
 rtl/prio_enc_rr.sv | 99 +++++++++
 tb/tb_prio_enc_rr.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/prio_enc_rr.sv
// Registered N-input priority encoder with fixed or round-robin selection and valid/ready output.
// Optional coalesced-request counter enabled by defining PE_COALESCE_CNT_EN.
module prio_enc_rr #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] idx,
  output logic         busy
`ifdef PE_COALESCE_CNT_EN
  ,
  output logic [7:0]   coal_cnt
`endif
);

  logic [N-1:0] pending_p0;
  logic [N-1:0] pending_nxt;
  logic [N-1:0] clr;
  logic [W-1:0] ptr_p0;
  logic [W-1:0] ptr_nxt;
  logic [W-1:0] sel;
  logic         fire;
  logic         load;

  function automatic logic [W-1:0] sel_fixed(input logic [N-1:0] v);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++)
      if (v[i]) r = W'(i);
    return r;
  endfunction

  // Scan downward from p-1, wrapping mod N, so the last grant ends up lowest priority.
  function automatic logic [W-1:0] sel_rr(input logic [N-1:0] v, input logic [W-1:0] p);
    logic [W-1:0] r;
    logic         found;
    int           j;
    r     = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(p) + N - k) % N;
      if (!found && v[j]) begin
        r     = W'(j);
        found = 1'b1;
      end
    end
    return r;
  endfunction

  always_comb begin
    fire = out_valid & out_ready;
    load = !out_valid || fire;
    clr  = '0;
    if (fire) clr[idx] = 1'b1;
    // Set wins over clear, so a re-request on the grant cycle stays pending.
    pending_nxt = (pending_p0 & ~clr) | req;
    // The pointer moves with the grant being accepted, so the next pick already sees it.
    ptr_nxt = fire ? idx : ptr_p0;
    sel     = mode ? sel_rr(pending_nxt, ptr_nxt) : sel_fixed(pending_nxt);
  end

  // Stage p0: pending vector, pointer and output holding register
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_p0 <= '0;
      ptr_p0     <= '0;
      out_valid  <= 1'b0;
      idx        <= '0;
    end else begin
      pending_p0 <= pending_nxt;
      ptr_p0     <= ptr_nxt;
      if (load) begin
        out_valid <= |pending_nxt;
        idx       <= sel;
      end
    end
  end

  assign busy = |pending_p0;

`ifdef PE_COALESCE_CNT_EN
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst)
      coal_cnt <= '0;
    else if (|(req & pending_p0 & ~clr))
      coal_cnt <= sat_inc(coal_cnt);
  end
`endif

endmodule

// File: tb/tb_prio_enc_rr.sv
// Directed self-checking bench for prio_enc_rr (N=8); coalesce checks run when PE_COALESCE_CNT_EN is defined.
module tb_prio_enc_rr;
  localparam int N = 8;
  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic         mode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] idx;
  logic         busy;
`ifdef PE_COALESCE_CNT_EN
  logic [7:0]   coal_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  prio_enc_rr #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .idx       (idx),
    .busy      (busy)
`ifdef PE_COALESCE_CNT_EN
    ,
    .coal_cnt  (coal_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = 8'hFF; mode = 1'b0; out_ready = 1'b0;

    // 1: reset ignores req
    tick(); tick();
    rst = 1'b0; req = '0;
    tick();
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_idx",   32'(idx),       0);
    chk("rst_busy",  32'(busy),      0);

    // 2: fixed priority drain of C8
    mode = 1'b0; out_ready = 1'b1; req = 8'hC8;
    tick(); req = '0;
    chk("fx_idx0", 32'(idx), 7);
    chk("fx_vld0", 32'(out_valid), 1);
    chk("fx_busy0", 32'(busy), 1);
    tick(); chk("fx_idx1", 32'(idx), 6);
    tick(); chk("fx_idx2", 32'(idx), 3);
    tick();
    chk("fx_vld_end",  32'(out_valid), 0);
    chk("fx_busy_end", 32'(busy), 0);

    // 3: held grant not displaced by higher priority arrival
    out_ready = 1'b0; req = 8'h01;
    tick(); req = 8'h80;
    chk("hold_idx0", 32'(idx), 0);
    tick(); req = '0;
    chk("hold_idx1", 32'(idx), 0);
    chk("hold_vld1", 32'(out_valid), 1);
    out_ready = 1'b1;
    tick(); chk("hold_idx2", 32'(idx), 7);
    tick(); chk("hold_vld3", 32'(out_valid), 0);

    // 4: round-robin alternates, fixed sticks at 7
    do_reset();
    mode = 1'b1; out_ready = 1'b1; req = 8'h81;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("rr_idx%0d", i), 32'(idx), (i % 2 == 0) ? 7 : 0);
    end
    mode = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("fx81_idx%0d", i), 32'(idx), 7);
    end
    req = '0;
    tick(); tick();
    chk("fx81_vld_end", 32'(out_valid), 0);

    // 5: same-cycle re-request stays pending; mid-stream reset
    do_reset();
    mode = 1'b0; out_ready = 1'b0; req = 8'h80;
    tick(); req = '0;
    chk("rereq_idx0", 32'(idx), 7);
    out_ready = 1'b1; req = 8'h80;
    tick(); req = '0;
    chk("rereq_vld1",  32'(out_valid), 1);
    chk("rereq_idx1",  32'(idx), 7);
    chk("rereq_busy1", 32'(busy), 1);
    tick();
    chk("rereq_vld2",  32'(out_valid), 0);
    chk("rereq_busy2", 32'(busy), 0);
    out_ready = 1'b0; req = 8'h0F;
    tick(); req = '0;
    chk("mid_idx", 32'(idx), 3);
    chk("mid_busy", 32'(busy), 1);
    rst = 1'b1;
    tick(); rst = 1'b0;
    chk("mid_rst_vld",  32'(out_valid), 0);
    chk("mid_rst_idx",  32'(idx), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    out_ready = 1'b1;
    tick();
    chk("mid_rst_stays", 32'(out_valid), 0);

`ifdef PE_COALESCE_CNT_EN
    // 6: coalesce counter and saturation
    do_reset();
    out_ready = 1'b0; req = 8'h04;
    tick(); tick(); tick();
    chk("coal_3", 32'(coal_cnt), 2);
    for (int i = 0; i < 300; i++) tick();
    chk("coal_sat", 32'(coal_cnt), 8'hFF);
    req = '0;
    do_reset();
    tick();
    chk("coal_rst", 32'(coal_cnt), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule
